uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-producing clients. It sits between the clients and the transmitter's host-side write port. It picks one pending requester, writes that requester's byte into the transmit holding register or FIFO, and returns an accept pulse to the requester. It then waits a fixed settle window so the transmitter's txrdy flag reflects the write before arbitrating again.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2
  } arb_state_e;

  localparam int MAX_REQ      = 8;
  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client request bundle plus transmitter host-side write port.
// The slave modport is the arbiter's view; master is the clients/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 txrdy;
  logic [7:0]           tx_wdata;
  logic                 tx_we;

  modport master (
    output req_valid, req_data, req_last, txrdy,
    input  req_ready, tx_wdata, tx_we
  );

  modport slave (
    input  req_valid, req_data, req_last, txrdy,
    output req_ready, tx_wdata, tx_we
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i,
// wrapping modulo N.
module uart_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_oh_o,
  output logic [IDW-1:0] gnt_idx_o,
  output logic           any_o
);

  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    // NOTE: every comb output gets a default before any branch, so no path leaves it unassigned (no latch).
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte clients.
// Define UART_TX_ARB_PKT_LOCK_EN to keep a requester granted until its req_last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int TXRDY_SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(TXRDY_SETTLE - 1);

  arb_state_e              state_q, state_d;
  logic [IDW-1:0]          ptr_q, ptr_d, grant_id_q, grant_id_d, ptr_next, pick_idx;
  logic [7:0]              tx_wdata_q, tx_wdata_d, sel_data;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      eligible, pick_oh, req_ready;
  logic                    pick_any, take, ptr_adv, tx_we;

  uart_rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .req_i     (eligible),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) sel_data |= bus.req_data[8*i +: 8];
    end
  end

  assign take     = (state_q == IDLE) && bus.txrdy && pick_any;
  assign ptr_next = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef UART_TX_ARB_PKT_LOCK_EN
  logic lock_q, lock_d, last_q, last_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      last_q <= last_d;
    end
  end

  // grant_id_q doubles as the locked index: it cannot change while locked.
  always_comb begin
    lock_d = lock_q;
    last_d = last_q;
    if (take)              last_d = bus.req_last[pick_idx];
    if (state_q == LOAD)   lock_d = !last_q;
  end

  assign eligible = lock_q ? (bus.req_valid & (NUM_REQ'(1) << grant_id_q)) : bus.req_valid;
  assign ptr_adv  = last_q;
`else
  assign eligible = bus.req_valid;
  assign ptr_adv  = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      tx_wdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      tx_wdata_q <= tx_wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    tx_wdata_d = tx_wdata_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d    = LOAD;
          grant_id_d = pick_idx;
          tx_wdata_d = sel_data;
        end
      end
      LOAD: begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LOAD;
        if (ptr_adv) ptr_d = ptr_next;
      end
      SETTLE: begin
        // txrdy is deliberately ignored here; the transmitter clears it a cycle late.
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_we     = 1'b0;
    req_ready = '0;
    busy_o    = 1'b1;
    unique case (state_q)
      IDLE: busy_o = 1'b0;
      LOAD: begin
        tx_we                 = 1'b1;
        req_ready[grant_id_q] = 1'b1;
      end
      SETTLE: busy_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  assign bus.tx_we     = tx_we;
  assign bus.req_ready = req_ready;
  assign bus.tx_wdata  = tx_wdata_q;
  assign grant_id_o    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TXRDY_SETTLE=2): per-cycle vector
// table plus hand-written sequences for contention, back-pressure, wrap, lock and reset.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] grant_id;
  logic       busy;
  int         checks   = 0;
  int         failures = 0;

  localparam logic [31:0] D0 = 32'h44A5_2233;  // req3=44 req2=A5 req1=22 req0=33

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .TXRDY_SETTLE(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .grant_id_o (grant_id),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       txrdy;
    logic       exp_we;
    logic [3:0] exp_ready;
    logic [7:0] exp_wdata;
    logic [1:0] exp_gid;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = D0;
    bus.req_last  = 4'b1111;
    bus.txrdy     = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(bus.tx_we),     32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_wdata"}, 32'(bus.tx_wdata),  32'd0);
    check({tag, "_gid"},   32'(grant_id),      32'd0);
    check({tag, "_busy"},  32'(busy),          32'd0);
  endtask

  // Ticks until tx_we (bounded), then checks latency and the whole write.
  task automatic wait_grant(input string tag, input int exp_id, input int exp_n,
                            input logic [7:0] exp_data);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.tx_we && n < 20);
    check({tag, "_latency"}, 32'(n),             32'(exp_n));
    check({tag, "_we"},      32'(bus.tx_we),     32'd1);
    check({tag, "_gid"},     32'(grant_id),      32'(exp_id));
    check({tag, "_ready"},   32'(bus.req_ready), 32'd1 << exp_id);
    check({tag, "_wdata"},   32'(bus.tx_wdata),  32'(exp_data));
    check({tag, "_busy"},    32'(busy),          32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //               valid    rdy we  ready    wdata  gid  busy
    vecs[0]  = '{4'b0100, 1, 1, 4'b0100, 8'hA5, 2'd2, 1};
    vecs[1]  = '{4'b0100, 1, 0, 4'b0000, 8'hA5, 2'd2, 1};
    vecs[2]  = '{4'b0000, 1, 0, 4'b0000, 8'hA5, 2'd2, 1};
    vecs[3]  = '{4'b0000, 1, 0, 4'b0000, 8'hA5, 2'd2, 0};
    vecs[4]  = '{4'b0010, 0, 0, 4'b0000, 8'hA5, 2'd2, 0};
    vecs[5]  = '{4'b0010, 1, 1, 4'b0010, 8'h22, 2'd1, 1};
    vecs[6]  = '{4'b0010, 1, 0, 4'b0000, 8'h22, 2'd1, 1};
    vecs[7]  = '{4'b0000, 1, 0, 4'b0000, 8'h22, 2'd1, 1};
    vecs[8]  = '{4'b0000, 1, 0, 4'b0000, 8'h22, 2'd1, 0};
    vecs[9]  = '{4'b1001, 1, 1, 4'b1000, 8'h44, 2'd3, 1};
    vecs[10] = '{4'b1001, 0, 0, 4'b0000, 8'h44, 2'd3, 1};
    vecs[11] = '{4'b1001, 0, 0, 4'b0000, 8'h44, 2'd3, 1};
    vecs[12] = '{4'b1001, 0, 0, 4'b0000, 8'h44, 2'd3, 0};
    vecs[13] = '{4'b1001, 1, 1, 4'b0001, 8'h33, 2'd0, 1};
    vecs[14] = '{4'b0000, 1, 0, 4'b0000, 8'h33, 2'd0, 1};

    // Reset state, then per-cycle vectors: single byte, txrdy low, wrap of ptr 3 -> 0.
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = D0;
    bus.req_last  = 4'b1111;
    bus.txrdy     = 1'b0;
    #1;
    check_reset_outputs("reset");
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.req_valid = vecs[i].valid;
      bus.txrdy     = vecs[i].txrdy;
      tick();
      check($sformatf("vec%0d_we", i),    32'(bus.tx_we),     32'(vecs[i].exp_we));
      check($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_wdata", i), 32'(bus.tx_wdata),  32'(vecs[i].exp_wdata));
      check($sformatf("vec%0d_gid", i),   32'(grant_id),      32'(vecs[i].exp_gid));
      check($sformatf("vec%0d_busy", i),  32'(busy),          32'(vecs[i].exp_busy));
    end

    // Contention: all four valid -> 0,1,2,3,0 spaced 2+TXRDY_SETTLE cycles.
    do_reset();
    bus.req_valid = 4'b1111;
    wait_grant("cont0", 0, 1, 8'h33);
    wait_grant("cont1", 1, 4, 8'h22);
    wait_grant("cont2", 2, 4, 8'hA5);
    wait_grant("cont3", 3, 4, 8'h44);
    wait_grant("cont4", 0, 4, 8'h33);

    // Back-pressure: txrdy low until cycle 10 -> strobe at cycle 11.
    do_reset();
    bus.req_valid = 4'b0010;
    for (int c = 0; c <= 10; c++) begin
      bus.txrdy = (c == 10);
      tick();
      check($sformatf("bp_c%0d_we", c + 1), 32'(bus.tx_we), 32'(c == 10));
    end
    check("bp_gid", 32'(grant_id), 32'd1);
    // Valid/data dropping and txrdy falling in LOAD do not cancel the committed write.
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.txrdy     = 1'b0;
    #1;
    check("viol_we",    32'(bus.tx_we),     32'd1);
    check("viol_wdata", 32'(bus.tx_wdata),  32'h22);
    check("viol_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    check("viol_settle_we", 32'(bus.tx_we), 32'd0);
    check("viol_settle_busy", 32'(busy), 32'd1);

    // Wrap: ptr=3 with requesters 0 and 3 valid -> 3 then 0.
    do_reset();
    bus.req_valid = 4'b0100;
    wait_grant("wrap_pre", 2, 1, 8'hA5);
    tick();
    bus.req_valid = 4'b1001;
    wait_grant("wrap_a", 3, 3, 8'h44);
    wait_grant("wrap_b", 0, 4, 8'h33);

    // Packet lock vs per-byte arbitration.
    do_reset();
    bus.req_last  = 4'b0000;
    bus.req_data  = {8'h00, 8'h00, 8'hB1, 8'hC0};
    bus.req_valid = 4'b0010;
    wait_grant("pkt_b1", 1, 1, 8'hB1);
    tick();
    bus.req_valid = 4'b0011;
    bus.req_data  = {8'h00, 8'h00, 8'hB2, 8'hC0};
`ifdef UART_TX_ARB_PKT_LOCK_EN
    wait_grant("pkt_b2", 1, 3, 8'hB2);
    tick();
    bus.req_data = {8'h00, 8'h00, 8'hB3, 8'hC0};
    bus.req_last = 4'b0010;
    wait_grant("pkt_b3", 1, 3, 8'hB3);
    tick();
    bus.req_valid = 4'b0001;
    wait_grant("pkt_c0", 0, 3, 8'hC0);
`else
    wait_grant("pkt_c0", 0, 3, 8'hC0);
    tick();
    bus.req_valid = 4'b0010;
    wait_grant("pkt_b2", 1, 3, 8'hB2);
`endif

    // Reset mid-SETTLE: outputs clear at once, next grant restarts from requester 0.
    do_reset();
    bus.req_valid = 4'b0100;
    wait_grant("rst_pre", 2, 1, 8'hA5);
    tick();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    bus.req_valid = 4'b1111;
    tick();
    reset_n = 1'b1;
    wait_grant("rst_post", 0, 1, 8'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
